urv_iram_host_bridge: RTL and testbench

//  Wishbone-classic slave that gives a host (debug/loader master) access to IRAM port B.

---
 rtl/urv_iram_host_bridge_pkg.sv | 18 +
 rtl/urv_iram_host_bridge.sv | 116 +++++++++++
 tb/tb_urv_iram_host_bridge.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/urv_iram_host_bridge_pkg.sv
// Shared definitions for the IRAM host bridge: FSM state type, RAM latency and address helper.
package urv_iram_host_bridge_pkg;

  // RAM clock-to-q in cycles; the IRAM model uses the same value.
  localparam int URV_IRAM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_CAPT  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  function automatic logic [31:0] word_addr(input logic [29:0] adr_word);
    return {adr_word, 2'b00};
  endfunction

endpackage

// File: rtl/urv_iram_host_bridge.sv
// Wishbone-classic slave giving a host master access to IRAM port B, hiding the
// RAM's registered read latency and rejecting out-of-range addresses with err.
module urv_iram_host_bridge
  import urv_iram_host_bridge_pkg::*;
#(
  parameter int g_size       = 65536,
  parameter int g_simulation = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_cyc_i,
  input  logic        host_stb_i,
  input  logic        host_we_i,
  input  logic [31:0] host_adr_i,
  input  logic [3:0]  host_sel_i,
  input  logic [31:0] host_dat_i,
  output logic [31:0] host_dat_o,
  output logic        host_ack_o,
  output logic        host_err_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [31:0] ram_a_o,
  output logic [3:0]  ram_bwe_o,
  output logic [31:0] ram_d_o,
  input  logic [31:0] ram_q_i
);

  // Widened by one bit so a full 32-bit address compares unsigned against the size.
  localparam logic [32:0] SIZE_EXT = 33'(g_size);

  state_t      state, state_nxt;
  logic        req;
  logic        in_range;
  logic        ack_nxt, err_nxt, en_nxt, we_nxt;
  logic [31:0] a_nxt, d_nxt, dat_nxt;
  logic [3:0]  bwe_nxt;

  assign req      = host_cyc_i & host_stb_i;
  assign in_range = {1'b0, host_adr_i} < SIZE_EXT;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    en_nxt    = 1'b0;
    we_nxt    = 1'b0;
    a_nxt     = ram_a_o;
    bwe_nxt   = ram_bwe_o;
    d_nxt     = ram_d_o;
    dat_nxt   = host_dat_o;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (!in_range) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DONE;
          end else if (host_we_i) begin
            en_nxt    = 1'b1;
            we_nxt    = 1'b1;
            a_nxt     = word_addr(host_adr_i[31:2]);
            bwe_nxt   = host_sel_i;
            d_nxt     = host_dat_i;
            ack_nxt   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            en_nxt    = 1'b1;
            a_nxt     = word_addr(host_adr_i[31:2]);
            bwe_nxt   = 4'b0000;
            state_nxt = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_nxt = host_cyc_i ? ST_RD_CAPT : ST_IDLE;
      // The RAM output is valid here; an abandoned cycle leaves host_dat_o untouched.
      ST_RD_CAPT: begin
        if (host_cyc_i) begin
          dat_nxt   = ram_q_i;
          ack_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_ack_o <= 1'b0;
      host_err_o <= 1'b0;
      host_dat_o <= '0;
      ram_en_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_a_o    <= '0;
      ram_bwe_o  <= '0;
      ram_d_o    <= '0;
    end else begin
      host_ack_o <= ack_nxt;
      host_err_o <= err_nxt;
      host_dat_o <= dat_nxt;
      ram_en_o   <= en_nxt;
      ram_we_o   <= we_nxt;
      ram_a_o    <= a_nxt;
      ram_bwe_o  <= bwe_nxt;
      ram_d_o    <= d_nxt;
    end
  end

endmodule

// File: tb/tb_urv_iram_host_bridge.sv
// Bench for urv_iram_host_bridge with a behavioural single-port RAM on port B.
module tb_urv_iram_host_bridge;

  localparam int SIZE  = 65536;
  localparam int WORDS = SIZE / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_w = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_r, ram_a, ram_d;
  logic [31:0] ram_q = '0;
  logic        ack, err, ram_en, ram_we;
  logic [3:0]  ram_bwe;

  always #5 clk = ~clk;

  urv_iram_host_bridge #(.g_size(SIZE), .g_simulation(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_cyc_i(cyc), .host_stb_i(stb), .host_we_i(we),
    .host_adr_i(adr), .host_sel_i(sel), .host_dat_i(dat_w),
    .host_dat_o(dat_r), .host_ack_o(ack), .host_err_o(err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_a_o(ram_a),
    .ram_bwe_o(ram_bwe), .ram_d_o(ram_d), .ram_q_i(ram_q)
  );

  // Port-B RAM: registered read, byte-enabled write.
  logic [31:0] mem [WORDS] = '{default: '0};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_bwe[b]) mem[ram_a[15:2]][8*b +: 8] <= ram_d[8*b +: 8];
      ram_q <= mem[ram_a[15:2]];
    end
  end

  // Pulse counters and handshake rule monitor.
  int   wr_pulses = 0, en_pulses = 0, proto_viol = 0;
  logic ack_q = 1'b0, err_q = 1'b0, en_q = 1'b0;
  always @(posedge clk) begin
    if (ram_en) en_pulses <= en_pulses + 1;
    if (ram_en && ram_we) wr_pulses <= wr_pulses + 1;
    if ((ack && err) || ((ack || err) && (ack_q || err_q)) || (ram_en && en_q))
      proto_viol <= proto_viol + 1;
    ack_q <= ack;
    err_q <= err;
    en_q  <= ram_en;
  end

  // Reference memory: a word array updated from the byte-select rule.
  logic [31:0] ref_mem [WORDS] = '{default: '0};
  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a) / 4;
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output logic got_ack,
                      output logic got_err, output logic [31:0] rdata);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    while (lat < 16 && !got_ack && !got_err) begin
      @(posedge clk); #1;
      lat++;
      got_ack = ack;
      got_err = err;
    end
    rdata = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int lat; logic ga, ge; logic [31:0] rd;
    xfer(1'b1, a, d, s, lat, ga, ge, rd);
    if (a < SIZE) begin
      chk({tag, "_wlat"}, 32'(lat), 32'd1);
      chk({tag, "_wack"}, {31'd0, ga}, 32'd1);
      ref_write(a, d, s);
    end else begin
      chk({tag, "_werr"}, {31'd0, ge}, 32'd1);
      chk({tag, "_welat"}, 32'(lat), 32'd1);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    int lat; logic ga, ge; logic [31:0] rd; int e0;
    e0 = en_pulses;
    xfer(1'b0, a, 32'd0, 4'hF, lat, ga, ge, rd);
    if (a < SIZE) begin
      chk({tag, "_rlat"}, 32'(lat), 32'd3);
      chk({tag, "_rack"}, {31'd0, ga}, 32'd1);
      chk({tag, "_rdat"}, rd, ref_mem[int'(a) / 4]);
    end else begin
      chk({tag, "_rerr"}, {31'd0, ge}, 32'd1);
      chk({tag, "_relat"}, 32'(lat), 32'd1);
      chk({tag, "_rnoack"}, {31'd0, ga}, 32'd0);
      chk({tag, "_rnoen"}, 32'(en_pulses - e0), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, w0, acks, last_c, lat;
    logic ga, ge;
    logic [31:0] rd, prev, a, d;
    logic [3:0] s;
    logic [31:0] bb_adr [4];
    logic [31:0] bb_dat [4];

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {dat_r[31:0]} | ram_a | ram_d, 32'd0);
    chk("rst_ctrl", {24'd0, ack, err, ram_en, ram_we, ram_bwe}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full write then read back.
    do_write("t1", 32'h10, 32'hDEADBEEF, 4'hF);
    do_read("t1", 32'h10);

    // Byte-lane write over existing data.
    do_write("t2", 32'h10, 32'h0000AA00, 4'b0010);
    do_read("t2", 32'h10);
    chk("t2_exact", ref_mem[4], 32'hDEADAAEF);

    // Out-of-range read: error, no RAM access, memory intact.
    do_read("t3", 32'h0001_0000);
    do_read("t3_hi", 32'hFFFF_FFFC);
    do_read("t3_mem", 32'h10);

    // Top in-range word and a sel=0 write that must still ack with no change.
    do_write("edge", 32'h0000_FFFF, 32'h89ABCDEF, 4'hF);
    do_read("edge", 32'h0000_FFFC);
    w0 = wr_pulses;
    do_write("sel0", 32'h10, 32'hFFFF_FFFF, 4'h0);
    chk("sel0_pulse", 32'(wr_pulses - w0), 32'd1);
    do_read("sel0", 32'h10);

    // Strobe held continuously over four writes.
    for (int i = 0; i < 4; i++) begin
      bb_adr[i] = 32'h40 + 32'(4 * i);
      bb_dat[i] = $urandom;
    end
    w0 = wr_pulses; acks = 0; last_c = 0; k = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = bb_adr[0]; dat_w = bb_dat[0];
    for (int c = 1; c <= 30 && k < 4; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        acks++;
        if (k > 0) chk("t4_spacing", 32'(c - last_c), 32'd2);
        last_c = c;
        ref_write(bb_adr[k], bb_dat[k], 4'hF);
        k++;
        if (k < 4) begin adr = bb_adr[k]; dat_w = bb_dat[k]; end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_acks", 32'(acks), 32'd4);
    chk("t4_pulses", 32'(wr_pulses - w0), 32'd4);
    for (int i = 0; i < 4; i++) do_read("t4_rd", bb_adr[i]);

    // Read abandoned in the capture cycle.
    do_write("t5_pre", 32'h20, 32'h1111_2222, 4'hF);
    do_write("t5_pre", 32'h24, 32'h3333_4444, 4'hF);
    do_read("t5_pre", 32'h10);
    prev = dat_r;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("t5_noack", 32'(acks), 32'd0);
    chk("t5_dathold", dat_r, prev);
    do_read("t5_next", 32'h24);

    // Asynchronous reset while in the capture state.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h24;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_dat", dat_r, 32'd0);
    chk("t6_addr", ram_a | ram_d, 32'd0);
    chk("t6_ctrl", {24'd0, ack, err, ram_en, ram_we, ram_bwe}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_read("t6_after", 32'h20);

    // Random mix against the reference memory.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = 32'h0001_0000 + ($urandom & 32'h7FFF_FFFF);
      else
        a = 32'({$urandom_range(64, 127), 2'b00}) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom);
        do_write("rnd", a, d, s);
      end else begin
        do_read("rnd", a);
      end
    end

    xfer(1'b0, 32'h100, 32'd0, 4'hF, lat, ga, ge, rd);
    chk("final_rd", rd, ref_mem[64]);
    chk("protocol", 32'(proto_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
